ff_mem_rd_stream: RTL and testbench

- Read-side engine for the flip-flop memory block (combinational read port: data follows address in the same cycle).
- Accepts a command (start address, beat count) and walks the memory address space, wrapping modulo DEPTH.
- Emits a registered valid/ready data stream with a last flag.
- Sits between a flip-flop memory and a downstream consumer (hash/cipher core or DMA-out).

---
 rtl/ff_mem_rd_stream.sv | 118 +++++++++++
 tb/tb_ff_mem_rd_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_mem_rd_stream.sv
// ff_mem_rd_stream
//   Read-side engine for a flip-flop memory with a combinational read port.
//   It accepts a command (start address, beat count), walks the memory ring
//   modulo DEPTH, and emits the words as a registered valid/ready stream.
//   The final beat of each command carries out_last. After that beat is
//   accepted, done pulses for one cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cmd_valid    command request
//   cmd_ready    command accept (IDLE only, low while rst is high)
//   cmd_addr     start address [AW-1:0]
//   cmd_len      beat count [AW:0], 0..2*DEPTH-1
//   mem_rd_addr  memory read address (the walking pointer)
//   mem_dout     memory read data for mem_rd_addr, same cycle
//   out_valid    output beat valid (registered)
//   out_ready    downstream accept
//   out_data     beat data (registered)
//   out_last     final beat of the command (registered)
//   done         one-cycle pulse on command completion (registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// RUN   | loading one beat per cycle whenever the output register is free
// DRAIN | last beat loaded; waiting for the downstream to take it
module ff_mem_rd_stream #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic          load;

  // The output register may take a new beat when it is empty or being drained.
  assign load        = !out_valid || out_ready;
  // Gated by rst so no command can be accepted during the reset edge.
  assign cmd_ready   = (state == S_IDLE) && !rst;
  assign mem_rd_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (load) begin
            // mem_dout is sampled at this edge. A memory write on the same
            // edge has not landed yet, so the pre-write word is captured.
            out_data  <= mem_dout;
            out_valid <= 1'b1;
            out_last  <= (remaining == LEN_ONE);
            ptr       <= ptr + 1'b1;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_mem_rd_stream.sv
// Testbench for ff_mem_rd_stream.
// The memory model lives here: it has a combinational read and a
// posedge-registered write. Expected beats come from a per-command queue
// snapshot of the memory. Expected timing comes from counting transfers.
module tb_ff_mem_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [4:0] cmd_len;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       done;

  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_rd_addr];

  ff_mem_rd_stream #(.DW(8), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .mem_rd_addr (mem_rd_addr),
    .mem_dout    (mem_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and checks the run through to the done cycle.
  // The task returns during the done cycle, in its second half.
  // mode: 0 = out_ready always high, 1 = fixed toggle pattern, 2 = random.
  // hold: leave cmd_valid high after acceptance, so a command can be chained.
  // imm:  the command must be accepted without waiting.
  // do_wr: write wd to mem[wa] on the edge that loads the beat for wa.
  task automatic run_cmd(input logic [3:0] a, input logic [4:0] n, input int mode,
                         input bit hold, input bit imm,
                         input bit do_wr, input logic [3:0] wa, input logic [7:0] wd);
    logic [7:0] q[$];
    bit         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         xf = 0;
    int         cyc = 0;
    int         last_cyc = -1;
    int         wait_c = 0;
    int         loaded;
    bit         ev, rdy, exp_done, wr_now, wr_used, finished;
    logic [3:0] ea;

    wr_used  = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      ea = a + 4'(i);
      q.push_back(mem[ea]);
    end

    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && wait_c < 50) begin
      tick();
      wait_c++;
    end
    chk("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    if (imm) chk("cmd_back_to_back_wait", 32'(wait_c), 32'd0);
    tick();
    cmd_valid = hold;

    while (!finished && cyc < 200) begin
      ev  = (cyc >= 1) && (xf < int'(n));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= 1 && cyc <= 6) ? pat[cyc-1] : 1'b1;
        default: rdy = 1'b1 & $urandom_range(0, 1);
      endcase
      out_ready = rdy;
      loaded    = xf + (ev ? 1 : 0);
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("out_data", 32'(out_data), 32'(q[xf]));
        chk("out_last", 32'(out_last), 32'(xf == int'(n) - 1));
      end
      ea = a + 4'(loaded);
      if (loaded < int'(n)) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(ea));
      exp_done = (n == 5'd0) ? (cyc == 0) : (last_cyc >= 0 && cyc == last_cyc + 1);
      chk("done", 32'(done), 32'(exp_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_done));
      wr_now = do_wr && !wr_used && (loaded < int'(n)) && (ea == wa) && (!ev || rdy);
      if (exp_done) begin
        finished = 1'b1;
      end else begin
        @(posedge clk);
        if (wr_now) begin
          mem[wa] <= wd;
          wr_used = 1'b1;
        end
        if (ev && rdy) begin
          if (xf == int'(n) - 1) last_cyc = cyc;
          xf++;
        end
        #1;
        cyc++;
      end
    end
    if (!finished) chk("cmd_completion_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);

    // Reset values
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_ptr",       32'(mem_rd_addr), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic read: beats 0x06, 0x09, 0x0C, 0x0F
    run_cmd(4'd2, 5'd4, 0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);

    // Wrap-around
    run_cmd(4'd14, 5'd4, 0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();

    // Backpressure, with out_ready following 1,0,0,1,0,1
    run_cmd(4'd7, 5'd3, 1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();

    // Zero length, then two chained len=1 commands
    run_cmd(4'd9, 5'd0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    run_cmd(4'd3, 5'd1, 0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    run_cmd(4'd4, 5'd1, 0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    tick();

    // Write collision: the beat carries the old word, and a re-read sees the new one
    mem[5] = 8'h11;
    run_cmd(4'd3, 5'd4, 0, 1'b0, 1'b0, 1'b1, 4'd5, 8'hAA);
    tick();
    chk("collision_mem_written", 32'(mem[5]), 32'hAA);
    run_cmd(4'd5, 5'd1, 0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    tick();

    // Reset mid-RUN, after 2 of 5 beats
    cmd_addr  = 4'd0;
    cmd_len   = 5'd5;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_done",      32'(done),      32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("after_rst_no_beat", 32'(out_valid), 32'd0);
      chk("after_rst_no_done", 32'(done), 32'd0);
    end

    // Random commands against a random memory image, with random backpressure
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      run_cmd(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 2,
              1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
